// File: rtl/fpu_pkg.sv
// Shared FPU definitions: team float format fields, result status encoding, field extractors.
package fpu_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned EXP_W    = 6;
    localparam int unsigned MANT_W   = 25;
    localparam int unsigned BIAS     = 31;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned STATUS_W = 4;

    typedef enum logic [STATUS_W-1:0] {
        EXACT     = 4'b0001,
        INEXACT   = 4'b0010,
        OVERFLOW  = 4'b0100,
        UNDERFLOW = 4'b1000
    } status_t;

    function automatic logic get_sign(input logic [WORD_W-1:0] word);
        return word[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] get_exp(input logic [WORD_W-1:0] word);
        return word[WORD_W-2 -: EXP_W];
    endfunction

    function automatic logic [MANT_W-1:0] get_mant(input logic [WORD_W-1:0] word);
        return word[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/fpu_result_decoder.sv
// Serial float-to-int converter on the FPU result bus: truncates toward zero,
// one bit of shift per cycle, valid/ready handshake on both sides.
module fpu_result_decoder
    import fpu_pkg::*;
(
    input  logic                clock100KHz,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    int_out,
    output logic [STATUS_W-1:0] status_out,
    output logic                busy
);

    localparam int unsigned CNT_W = 5;
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [EXP_W-1:0] EXP_TOP  = EXP_W'(62);
    localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
    // Exponent at which the stored significand already is an integer (no shift).
    localparam logic [EXP_W-1:0] EXP_REF  = EXP_W'(BIAS + MANT_W);
    localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, PACK, DONE} state_t;

    state_t               state, state_nx;
    logic                 sign_q, sign_nx;
    logic [EXP_W-1:0]     exp_q, exp_nx;
    logic [OUT_W-1:0]     acc_q, acc_nx;
    logic                 sticky_q, sticky_nx;
    logic                 left_q, left_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx;
    logic                 out_valid_nx;
    logic [OUT_W-1:0]     int_nx;
    logic [STATUS_W-1:0]  status_nx;
    logic                 mant_zero;

    assign mant_zero = (acc_q[MANT_W-1:0] == '0);

    // Next-state and datapath update
    always_comb begin
        state_nx     = state;
        sign_nx      = sign_q;
        exp_nx       = exp_q;
        acc_nx       = acc_q;
        sticky_nx    = sticky_q;
        left_nx      = left_q;
        cnt_nx       = cnt_q;
        out_valid_nx = out_valid;
        int_nx       = int_out;
        status_nx    = status_out;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nx   = get_sign(data_in);
                    exp_nx    = get_exp(data_in);
                    acc_nx    = OUT_W'({1'b1, get_mant(data_in)});
                    sticky_nx = 1'b0;
                    state_nx  = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (exp_q == EXP_ZERO) begin
                    int_nx       = '0;
                    status_nx    = mant_zero ? EXACT : UNDERFLOW;
                    out_valid_nx = 1'b1;
                    state_nx     = DONE;
                end else if (exp_q < EXP_BIAS) begin
                    int_nx       = '0;
                    status_nx    = UNDERFLOW;
                    out_valid_nx = 1'b1;
                    state_nx     = DONE;
                end else if (exp_q == EXP_MAX || (exp_q == EXP_TOP && !(sign_q && mant_zero))) begin
                    int_nx       = sign_q ? SAT_NEG : SAT_POS;
                    status_nx    = OVERFLOW;
                    out_valid_nx = 1'b1;
                    state_nx     = DONE;
                end else if (exp_q < EXP_REF) begin
                    left_nx  = 1'b0;
                    cnt_nx   = CNT_W'(EXP_REF - exp_q);
                    state_nx = SHIFT;
                end else if (exp_q > EXP_REF) begin
                    left_nx  = 1'b1;
                    cnt_nx   = CNT_W'(exp_q - EXP_REF);
                    state_nx = SHIFT;
                end else begin
                    state_nx = PACK;
                end
            end
            SHIFT: begin
                if (left_q) begin
                    acc_nx = acc_q << 1;
                end else begin
                    sticky_nx = sticky_q | acc_q[0];
                    acc_nx    = acc_q >> 1;
                end
                cnt_nx = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_nx = PACK;
                end
            end
            PACK: begin
                int_nx       = sign_q ? -acc_q : acc_q;
                status_nx    = sticky_q ? INEXACT : EXACT;
                out_valid_nx = 1'b1;
                state_nx     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_nx = 1'b0;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            state      <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            left_q     <= 1'b0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            int_out    <= '0;
            status_out <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            sign_q     <= sign_nx;
            exp_q      <= exp_nx;
            acc_q      <= acc_nx;
            sticky_q   <= sticky_nx;
            left_q     <= left_nx;
            cnt_q      <= cnt_nx;
            out_valid  <= out_valid_nx;
            int_out    <= int_nx;
            status_out <= status_nx;
            in_ready   <= (state_nx == IDLE);
            busy       <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_fpu_result_decoder.sv
// Directed bench for fpu_result_decoder: values, status, latency, backpressure, reset abort.
module tb_fpu_result_decoder;

    logic        clock100KHz;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_out;
    logic [3:0]  status_out;
    logic        busy;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp_int;
        logic [3:0]  exp_status;
        int          exp_lat;
    } vec_t;

    vec_t vecs[12];

    fpu_result_decoder dut (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .int_out     (int_out),
        .status_out  (status_out),
        .busy        (busy)
    );

    initial clock100KHz = 1'b0;
    always #5 clock100KHz = ~clock100KHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Accept one word; returns number of edges from accept until out_valid is seen.
    task automatic issue(input logic [31:0] word, output int lat);
        @(negedge clock100KHz);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        data_in  = word;
        in_valid = 1'b1;
        @(posedge clock100KHz);
        #1 in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clock100KHz);
            if (out_valid || lat > 60) break;
            @(posedge clock100KHz);
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.word, lat);
        check($sformatf("latency_%08h", v.word), 32'(lat), 32'(v.exp_lat));
        check($sformatf("int_%08h", v.word), int_out, v.exp_int);
        check($sformatf("status_%08h", v.word), 32'(status_out), 32'(v.exp_status));
        @(posedge clock100KHz);
        @(negedge clock100KHz);
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] held_int;
        logic [3:0]  held_status;

        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;

        vecs[0]  = '{32'h3E000000, 32'h00000001, 4'b0001, 28};
        vecs[1]  = '{32'hC0800000, 32'hFFFFFFFE, 4'b0010, 27};
        vecs[2]  = '{32'h70000001, 32'h02000001, 4'b0001, 3};
        vecs[3]  = '{32'hFC000000, 32'h80000000, 4'b0001, 9};
        vecs[4]  = '{32'h7C000000, 32'h7FFFFFFF, 4'b0100, 2};
        vecs[5]  = '{32'hFE000000, 32'h80000000, 4'b0100, 2};
        vecs[6]  = '{32'h20000000, 32'h00000000, 4'b1000, 2};
        vecs[7]  = '{32'h00000000, 32'h00000000, 4'b0001, 2};
        vecs[8]  = '{32'h80000000, 32'h00000000, 4'b0001, 2};
        vecs[9]  = '{32'h7A000000, 32'h40000000, 4'b0001, 8};
        vecs[10] = '{32'hBE000001, 32'hFFFFFFFF, 4'b0010, 28};
        vecs[11] = '{32'h3C000000, 32'h00000000, 4'b1000, 2};

        repeat (3) @(posedge clock100KHz);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_int_out", int_out, 32'd0);
        check("rst_status", 32'(status_out), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: hold result, refuse a second word while busy
        out_ready = 1'b0;
        issue(32'h70000001, lat);
        check("bp_latency", 32'(lat), 32'd3);
        held_int    = int_out;
        held_status = status_out;
        check("bp_int", held_int, 32'h02000001);
        check("bp_status", 32'(held_status), 32'b0001);
        data_in  = 32'h3E000000;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock100KHz);
            @(negedge clock100KHz);
            check("bp_out_valid_held", 32'(out_valid), 32'd1);
            check("bp_int_held", int_out, held_int);
            check("bp_status_held", 32'(status_out), 32'(held_status));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock100KHz);
        @(negedge clock100KHz);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_int_kept", int_out, 32'h02000001);

        // Reset during SHIFT aborts the word in flight
        @(negedge clock100KHz);
        data_in  = 32'h3E000000;
        in_valid = 1'b1;
        @(posedge clock100KHz);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clock100KHz);
        @(negedge clock100KHz);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clock100KHz);
        #1;
        reset = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_int_out", int_out, 32'd0);
        check("abort_status", 32'(status_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
